rst_seq: RTL and testbench

Staged reset sequencer directly downstream of the board reset conditioner. It takes the conditioned system reset, releases the memory, peripheral and CPU reset domains one after another with programmable gaps, and re-runs a partial sequence on a software reset request. Memory contents survive a soft reset. It exposes a sequencing-done flag and a soft-reset counter for status registers.

---
 rtl/rst_seq.sv | 128 ++++++++++++
 tb/tb_rst_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases memory, peripheral and CPU reset domains in order,
// and re-runs the peripheral/CPU part of the sequence on a software request.
module rst_seq #(
  parameter int unsigned STAGE_GAP = 16,
  parameter int unsigned SOFT_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset_in_n,
  input  logic       soft_rst_req,
  output logic       mem_rst,
  output logic       periph_rst,
  output logic       cpu_rst,
  output logic       seq_done,
  output logic [7:0] rst_count
);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_PERIPH,
    WAIT_CPU,
    RUN,
    SOFT
  } state_e;

  localparam logic [15:0] GapLast  = 16'(STAGE_GAP - 1);
  localparam logic [15:0] HoldLast = 16'(SOFT_HOLD - 1);

  logic [1:0]  sync_q;
  state_e      state_q;
  logic [15:0] cnt_q;
  logic        mem_q;
  logic        periph_q;
  logic        cpu_q;
  logic        done_q;
  logic [7:0]  count_q;

  // Reset assertion is immediate; its release is delayed two edges so the FSM never
  // sees a deassertion that races the clock.
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      mem_q    <= 1'b1;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else if (sync_q[1]) begin
      case (state_q)
        HOLD: begin
          if (cnt_q == GapLast) begin
            state_q <= WAIT_PERIPH;
            cnt_q   <= '0;
            mem_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WAIT_PERIPH: begin
          if (cnt_q == GapLast) begin
            state_q  <= WAIT_CPU;
            cnt_q    <= '0;
            periph_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WAIT_CPU: begin
          if (cnt_q == GapLast) begin
            state_q <= RUN;
            cnt_q   <= '0;
            cpu_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RUN: begin
          // Only RUN listens to the request, so a held request fires once per RUN entry.
          if (soft_rst_req) begin
            state_q  <= SOFT;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            done_q   <= 1'b0;
            if (count_q != 8'hFF) begin
              count_q <= count_q + 8'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SOFT: begin
          if (cnt_q == HoldLast) begin
            state_q  <= WAIT_CPU;
            cnt_q    <= '0;
            periph_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q  <= HOLD;
          cnt_q    <= '0;
          mem_q    <= 1'b1;
          periph_q <= 1'b1;
          cpu_q    <= 1'b1;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rst    = mem_q;
  assign periph_rst = periph_q;
  assign cpu_rst    = cpu_q;
  assign seq_done   = done_q;
  assign rst_count  = count_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues the expected output changes with the
// edge they must land on; a negedge monitor pops and compares on every output change.
module tb_rst_seq;

  localparam int Gap  = 16;
  localparam int Hold = 8;

  logic       clock = 1'b0;
  logic       reset_in_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       mem_rst;
  logic       periph_rst;
  logic       cpu_rst;
  logic       seq_done;
  logic [7:0] rst_count;
  logic [11:0] curVal;

  typedef struct {
    string       name;
    int          edgeNo;
    logic [11:0] val;
  } expT;

  expT         expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edgeCnt = 0;
  bit          monOn = 1'b0;
  logic [11:0] prevVal = '0;

  rst_seq #(
    .STAGE_GAP(Gap),
    .SOFT_HOLD(Hold)
  ) dut (
    .clock       (clock),
    .reset_in_n  (reset_in_n),
    .soft_rst_req(soft_rst_req),
    .mem_rst     (mem_rst),
    .periph_rst  (periph_rst),
    .cpu_rst     (cpu_rst),
    .seq_done    (seq_done),
    .rst_count   (rst_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCnt++;

  assign curVal = {mem_rst, periph_rst, cpu_rst, seq_done, rst_count};

  function automatic logic [11:0] packVal(input logic m, input logic p, input logic c,
                                          input logic d, input logic [7:0] n);
    return {m, p, c, d, n};
  endfunction

  // Any output change must match the head of the queue, both in value and in edge.
  always @(negedge clock) begin : monitor
    expT e;
    if (monOn && (curVal !== prevVal)) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_change at edge %0d: got %h, required %h (no change)",
                 edgeCnt, curVal, prevVal);
      end else begin
        e = expQ.pop_front();
        if (e.edgeNo != edgeCnt || e.val !== curVal) begin
          miscompares++;
          $display("[TB] FAIL %s: got %h at edge %0d, required %h at edge %0d",
                   e.name, curVal, edgeCnt, e.val, e.edgeNo);
        end
      end
      prevVal = curVal;
    end
  end

  task automatic pushExp(input string name, input int edgeNo, input logic [11:0] val);
    expT e;
    e.name   = name;
    e.edgeNo = edgeNo;
    e.val    = val;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [11:0] req);
    vectors++;
    if (curVal !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, curVal, req);
    end
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    for (int i = 0; i < maxCycles && expQ.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s: %0d expected changes never seen, required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  // Drives the request on a negedge; returns the edge that will sample it.
  task automatic applyStimulus(input logic level, output int sampleEdge);
    @(negedge clock);
    soft_rst_req = level;
    sampleEdge   = edgeCnt + 1;
  endtask

  task automatic hardRelease(output int e0);
    @(negedge clock);
    prevVal    = curVal;
    monOn      = 1'b1;
    reset_in_n = 1'b1;
    e0         = edgeCnt + 2;
    pushExp("mem_release", e0 + Gap, packVal(0, 1, 1, 0, 8'd0));
    pushExp("periph_release", e0 + 2 * Gap, packVal(0, 0, 1, 0, 8'd0));
    pushExp("cpu_release", e0 + 3 * Gap, packVal(0, 0, 0, 1, 8'd0));
  endtask

  task automatic pushSoft(input int s, input logic [7:0] n);
    pushExp("soft_enter", s, packVal(0, 1, 1, 0, n));
    pushExp("soft_periph_release", s + Hold, packVal(0, 0, 1, 0, n));
    pushExp("soft_cpu_release", s + Hold + Gap, packVal(0, 0, 0, 1, n));
  endtask

  initial begin : stimulus
    int e0;
    int s;
    int dummy;
    int n;

    #2 reset_in_n = 1'b0;
    #1 checkOutput("reset_assert", packVal(1, 1, 1, 0, 8'd0));
    repeat (3) @(negedge clock);
    checkOutput("reset_held", packVal(1, 1, 1, 0, 8'd0));

    // Hard release with a request pulse landing in WAIT_PERIPH, which must be ignored.
    hardRelease(e0);
    while (edgeCnt < e0 + 19) @(negedge clock);
    soft_rst_req = 1'b1;
    @(negedge clock);
    soft_rst_req = 1'b0;
    waitDrain("hard_sequence", 200);
    checkOutput("ignored_request", packVal(0, 0, 0, 1, 8'd0));

    repeat (3) @(negedge clock);
    applyStimulus(1'b1, s);
    pushSoft(s, 8'd1);
    applyStimulus(1'b0, dummy);
    waitDrain("single_soft", 200);
    checkOutput("single_soft_done", packVal(0, 0, 0, 1, 8'd1));

    // Held request: each RUN entry accepts again on its first cycle.
    repeat (2) @(negedge clock);
    applyStimulus(1'b1, s);
    for (int i = 0; i < 3; i++) pushSoft(s + 25 * i, 8'(2 + i));
    while (edgeCnt < s + 52) @(negedge clock);
    soft_rst_req = 1'b0;
    waitDrain("held_request", 300);
    checkOutput("held_count", packVal(0, 0, 0, 1, 8'd4));

    repeat (2) @(negedge clock);
    applyStimulus(1'b1, s);
    for (int i = 0; i < 256; i++) begin
      n = (5 + i > 255) ? 255 : 5 + i;
      pushSoft(s + 25 * i, 8'(n));
    end
    while (edgeCnt < s + 25 * 255 + 2) @(negedge clock);
    soft_rst_req = 1'b0;
    waitDrain("saturation", 25 * 256 + 200);
    checkOutput("saturated_count", packVal(0, 0, 0, 1, 8'd255));

    // Hard reset between edges in the middle of a soft reset.
    repeat (2) @(negedge clock);
    applyStimulus(1'b1, s);
    pushExp("mid_soft_enter", s, packVal(0, 1, 1, 0, 8'd255));
    applyStimulus(1'b0, dummy);
    while (edgeCnt < s + 4) @(negedge clock);
    #1;
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_soft_enter_seen: %0d pending, required 0", expQ.size());
      expQ.delete();
    end
    monOn = 1'b0;
    reset_in_n = 1'b0;
    #1 checkOutput("mid_reset_assert", packVal(1, 1, 1, 0, 8'd0));
    repeat (3) @(negedge clock);
    checkOutput("mid_reset_held", packVal(1, 1, 1, 0, 8'd0));
    hardRelease(e0);
    waitDrain("rerun_hard_sequence", 200);
    checkOutput("rerun_final", packVal(0, 0, 0, 1, 8'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
